// File: rtl/rvv_lsu_responder.sv
// Vector LSU responder: in-order request FIFO with fixed minimum latency in front of a byte-strobed backing memory.
// Optional RVV_LSU_RSP_BACKPRESSURE_EN gates req_ready with a free-running 16-bit LFSR.
module rvv_lsu_responder #(
  parameter int unsigned VLEN      = 128,
  parameter int unsigned MEM_DEPTH = 64,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned LATENCY   = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [31:0]                req_pc,
  input  logic                       req_is_load,
  input  logic [4:0]                 req_vidx,
  input  logic [$clog2(MEM_DEPTH)-1:0] req_addr,
  input  logic [VLEN/8-1:0]          req_strb,
  input  logic [VLEN-1:0]            req_data,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [31:0]                rsp_pc,
  output logic                       rsp_is_load,
  output logic [4:0]                 rsp_vidx,
  output logic [VLEN-1:0]            rsp_data,
  output logic [$clog2(DEPTH):0]     outstanding
);

  localparam int unsigned VLENB = VLEN / 8;
  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned OW    = PW + 1;
  localparam int unsigned CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef struct packed {
    logic [31:0]     pc;
    logic            is_load;
    logic [4:0]      vidx;
    logic [VLEN-1:0] data;
    logic [CW-1:0]   cnt;
  } entry_t;

  entry_t          fifo [DEPTH];
  logic [VLEN-1:0] mem  [MEM_DEPTH];
  logic [PW-1:0]   wptr, rptr;
  logic [OW-1:0]   count;
  logic            full, empty, push, pop;
  entry_t          head, new_entry;

  assign empty = (count == '0);
  assign full  = (count == OW'(DEPTH));

`ifdef RVV_LSU_RSP_BACKPRESSURE_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end
  end

  assign req_ready = rst_n && !full && lfsr[0];
`else
  assign req_ready = rst_n && !full;
`endif

  assign push = req_valid && req_ready;
  assign pop  = rsp_valid && rsp_ready;
  assign head = fifo[rptr];

  // Load data is sampled from memory before any same-edge store lands
  always_comb begin
    new_entry         = '0;
    new_entry.pc      = req_pc;
    new_entry.is_load = req_is_load;
    new_entry.vidx    = req_vidx;
    new_entry.data    = req_is_load ? mem[req_addr] : '0;
    new_entry.cnt     = CW'(LATENCY - 1);
  end

  always_comb begin
    rsp_valid   = 1'b0;
    rsp_pc      = '0;
    rsp_is_load = 1'b0;
    rsp_vidx    = '0;
    rsp_data    = '0;
    if (!empty) begin
      rsp_valid   = (head.cnt == '0);
      rsp_pc      = head.pc;
      rsp_is_load = head.is_load;
      rsp_vidx    = head.vidx;
      rsp_data    = head.data;
    end
  end

  assign outstanding = count;

  // Empty slots always hold cnt=0, so counting down every nonzero slot only touches live entries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (push && (wptr == PW'(i))) begin
          fifo[i] <= new_entry;
        end else if (fifo[i].cnt != '0) begin
          fifo[i].cnt <= fifo[i].cnt - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + OW'(1);
        2'b01:   count <= count - OW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < int'(MEM_DEPTH); w++) begin
        mem[w] <= '0;
      end
    end else if (push && !req_is_load) begin
      for (int b = 0; b < int'(VLENB); b++) begin
        if (req_strb[b]) mem[req_addr][8*b +: 8] <= req_data[8*b +: 8];
      end
    end
  end

endmodule

// File: doc/rvv_lsu_responder.md
RVV_LSU_RESPONDER -- requirements
Module: rvv_lsu_responder

Interface
REQ-001 The block SHALL have parameter VLEN, default 128, meaning vector register width in bits; VLENB = VLEN/8.
REQ-002 The block SHALL have parameter MEM_DEPTH, default 64, meaning number of VLEN-bit words in the backing memory; AW = log2(MEM_DEPTH).
REQ-003 The block SHALL have parameter DEPTH, default 4, meaning outstanding-request FIFO entries (power of 2, >=2).
REQ-004 The block SHALL have parameter LATENCY, default 3, meaning minimum cycles from request accept to response valid (>=1).
REQ-005 The block SHALL have ports, one per line:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  LSU uop valid, backend to responder.
- req_ready  output  1  responder can accept a request.
- req_pc  input  32  uop PC tag.
- req_is_load  input  1  1 = load, 0 = store.
- req_vidx  input  5  destination/source vector register index.
- req_addr  input  AW  memory word address.
- req_strb  input  VLENB  store byte enables.
- req_data  input  VLEN  store data.
- rsp_valid  output  1  response valid, responder to backend.
- rsp_ready  input  1  backend accepts response.
- rsp_pc  output  32  echoed req_pc.
- rsp_is_load  output  1  echoed req_is_load.
- rsp_vidx  output  5  echoed req_vidx.
- rsp_data  output  VLEN  load data; 0 for stores.
- outstanding  output  log2(DEPTH)+1  current FIFO occupancy.

Function
REQ-006 A request SHALL be accepted on a rising edge where req_valid && req_ready.
REQ-007 Without the configuration macro, req_ready SHALL equal !full; no combinational path from rsp_ready to req_ready.
REQ-008 On an accepted store, memory bytes with req_strb[b]=1 SHALL be written at that edge; other bytes unchanged.
REQ-009 On an accepted load, the memory word at req_addr SHALL be read in the accept cycle, before any same-edge write, and captured into the FIFO entry.
REQ-010 Each accepted request SHALL push one entry {pc, is_load, vidx, data, cnt=LATENCY-1}; store entries carry data=0.
REQ-011 Each cycle, every valid entry with cnt!=0 SHALL decrement cnt by 1; cnt SHALL saturate at 0.
REQ-012 rsp_valid SHALL be 1 iff the FIFO is non-empty and head cnt==0; rsp_* SHALL be driven from the head entry.
REQ-013 Responses SHALL return strictly in accept order; the head SHALL pop on an edge where rsp_valid && rsp_ready.
REQ-014 Once asserted, rsp_valid and rsp_* SHALL hold stable until the handshake completes.
REQ-015 Simultaneous push and pop SHALL keep occupancy unchanged; read/write pointers SHALL wrap modulo DEPTH.
REQ-016 With LATENCY=1, rsp_valid SHALL assert in the cycle immediately after acceptance.
REQ-017 outstanding SHALL equal pushes minus pops since reset, range 0..DEPTH.

Reset
REQ-018 While rst_n=0: FIFO empty, pointers 0, all cnt 0, req_ready=0 until rst_n deasserts, rsp_valid=0, rsp_* = 0, outstanding=0, memory contents all 0.
REQ-019 Reset asserted mid-transaction SHALL discard all outstanding entries without producing responses.

Configuration
REQ-020 With RVV_LSU_RSP_BACKPRESSURE_EN defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 at reset; advances every cycle) SHALL gate req_ready = !full && lfsr[0]; without it, the LFSR SHALL not exist and REQ-007 applies.

Verification
REQ-021 Store addr 5, strb all-1, data 128'hA5..A5; then load addr 5 -> rsp_data=128'hA5..A5, rsp_is_load=1, LATENCY cycles after load accept.
REQ-022 Store addr 7 strb 16'h0001 data 0xFF -> later load addr 7 returns 128'h...00FF, upper bytes 0.
REQ-023 Five back-to-back requests with rsp_ready=0 -> req_ready=0 after 4th accept, outstanding=4; release rsp_ready -> responses in pc order.
REQ-024 Load and store same addr on consecutive cycles, load first -> load returns pre-store value.
REQ-025 rst_n pulsed low with 3 entries outstanding -> rsp_valid=0, outstanding=0, no stale responses afterwards.
REQ-026 Macro defined, continuous req_valid for 64 cycles -> req_ready follows lfsr[0] exactly; no requests lost or duplicated.
